// File: rtl/icb2axi_mport.sv
// ICB-to-AXI4 single-beat master port with in-order response return.
// Optional misaligned-address trapping is enabled by defining ICB2AXI_MISALIGN_CHK_EN.
module icb2axi_mport #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int OUTS_DEPTH = 8,
    parameter int AXI_ID     = 0,
    parameter int IDW        = 4,
    localparam int MW        = DW / 8
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           i_icb_cmd_valid,
    output logic           i_icb_cmd_ready,
    input  logic           i_icb_cmd_read,
    input  logic [AW-1:0]  i_icb_cmd_addr,
    input  logic [DW-1:0]  i_icb_cmd_wdata,
    input  logic [MW-1:0]  i_icb_cmd_wmask,
    output logic           i_icb_rsp_valid,
    input  logic           i_icb_rsp_ready,
    output logic           i_icb_rsp_err,
    output logic [DW-1:0]  i_icb_rsp_rdata,

    output logic           o_axi_arvalid,
    input  logic           o_axi_arready,
    output logic [IDW-1:0] o_axi_arid,
    output logic [AW-1:0]  o_axi_araddr,
    output logic [7:0]     o_axi_arlen,
    output logic [2:0]     o_axi_arsize,
    output logic [1:0]     o_axi_arburst,
    output logic           o_axi_arlock,
    output logic [3:0]     o_axi_arcache,
    output logic [2:0]     o_axi_arprot,

    output logic           o_axi_awvalid,
    input  logic           o_axi_awready,
    output logic [IDW-1:0] o_axi_awid,
    output logic [AW-1:0]  o_axi_awaddr,
    output logic [7:0]     o_axi_awlen,
    output logic [2:0]     o_axi_awsize,
    output logic [1:0]     o_axi_awburst,
    output logic           o_axi_awlock,
    output logic [3:0]     o_axi_awcache,
    output logic [2:0]     o_axi_awprot,

    output logic           o_axi_wvalid,
    input  logic           o_axi_wready,
    output logic [DW-1:0]  o_axi_wdata,
    output logic [MW-1:0]  o_axi_wstrb,
    output logic           o_axi_wlast,

    input  logic           o_axi_rvalid,
    output logic           o_axi_rready,
    input  logic [IDW-1:0] o_axi_rid,
    input  logic [DW-1:0]  o_axi_rdata,
    input  logic [1:0]     o_axi_rresp,
    input  logic           o_axi_rlast,

    input  logic           o_axi_bvalid,
    output logic           o_axi_bready,
    input  logic [IDW-1:0] o_axi_bid,
    input  logic [1:0]     o_axi_bresp
);

    localparam int SZ = $clog2(MW);
    localparam int PW = $clog2(OUTS_DEPTH);

    typedef enum logic [1:0] {
        TAG_RD  = 2'd0,
        TAG_WR  = 2'd1,
        TAG_ERR = 2'd2
    } tag_e;

    logic          ar_pend, aw_pend, w_pend;
    logic [AW-1:0] ar_addr_q, aw_addr_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wstrb_q;
    tag_e          tag_mem [OUTS_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    tag_e          head_tag, push_tag;
    logic          cmd_acc, cmd_err, pop;
`ifdef ICB2AXI_MISALIGN_CHK_EN
    logic          err_vld;
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_tag   = tag_mem[rd_ptr[PW-1:0]];

    assign i_icb_cmd_ready = !fifo_full && !ar_pend && !aw_pend && !w_pend;
    assign cmd_acc         = i_icb_cmd_valid && i_icb_cmd_ready;

`ifdef ICB2AXI_MISALIGN_CHK_EN
    assign cmd_err = |i_icb_cmd_addr[SZ-1:0];
`else
    assign cmd_err = 1'b0;
`endif

    assign push_tag = cmd_err ? TAG_ERR : (i_icb_cmd_read ? TAG_RD : TAG_WR);

    // Response source follows the oldest outstanding command; the other channel is stalled.
    always_comb begin
        i_icb_rsp_valid = 1'b0;
        i_icb_rsp_err   = 1'b0;
        i_icb_rsp_rdata = '0;
        o_axi_rready    = 1'b0;
        o_axi_bready    = 1'b0;
        if (!fifo_empty) begin
            case (head_tag)
                TAG_RD: begin
                    i_icb_rsp_valid = o_axi_rvalid;
                    i_icb_rsp_err   = o_axi_rresp[1];
                    i_icb_rsp_rdata = o_axi_rdata;
                    o_axi_rready    = i_icb_rsp_ready;
                end
                TAG_WR: begin
                    i_icb_rsp_valid = o_axi_bvalid;
                    i_icb_rsp_err   = o_axi_bresp[1];
                    o_axi_bready    = i_icb_rsp_ready;
                end
                default: begin
`ifdef ICB2AXI_MISALIGN_CHK_EN
                    i_icb_rsp_valid = err_vld;
                    i_icb_rsp_err   = 1'b1;
`endif
                end
            endcase
        end
    end

    assign pop = i_icb_rsp_valid && i_icb_rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
`ifdef ICB2AXI_MISALIGN_CHK_EN
            err_vld <= 1'b0;
`endif
        end else begin
            if (cmd_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            if (o_axi_arvalid && o_axi_arready) ar_pend <= 1'b0;
            if (o_axi_awvalid && o_axi_awready) aw_pend <= 1'b0;
            if (o_axi_wvalid && o_axi_wready)   w_pend  <= 1'b0;

            if (cmd_acc && !cmd_err) begin
                if (i_icb_cmd_read) begin
                    ar_pend <= 1'b1;
                end else begin
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                end
            end
`ifdef ICB2AXI_MISALIGN_CHK_EN
            // Trapped responses appear one cycle after the entry becomes the head.
            err_vld <= !fifo_empty && (head_tag == TAG_ERR) && !pop;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_acc) begin
            tag_mem[wr_ptr[PW-1:0]] <= push_tag;
            if (i_icb_cmd_read) begin
                ar_addr_q <= i_icb_cmd_addr;
            end else begin
                aw_addr_q <= i_icb_cmd_addr;
                wdata_q   <= i_icb_cmd_wdata;
                wstrb_q   <= i_icb_cmd_wmask;
            end
        end
    end

    assign o_axi_arvalid = ar_pend;
    assign o_axi_arid    = IDW'(AXI_ID);
    assign o_axi_araddr  = ar_addr_q;
    assign o_axi_arlen   = 8'd0;
    assign o_axi_arsize  = 3'(SZ);
    assign o_axi_arburst = 2'b01;
    assign o_axi_arlock  = 1'b0;
    assign o_axi_arcache = 4'b0011;
    assign o_axi_arprot  = 3'b000;

    assign o_axi_awvalid = aw_pend;
    assign o_axi_awid    = IDW'(AXI_ID);
    assign o_axi_awaddr  = aw_addr_q;
    assign o_axi_awlen   = 8'd0;
    assign o_axi_awsize  = 3'(SZ);
    assign o_axi_awburst = 2'b01;
    assign o_axi_awlock  = 1'b0;
    assign o_axi_awcache = 4'b0011;
    assign o_axi_awprot  = 3'b000;

    assign o_axi_wvalid  = w_pend;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wlast   = 1'b1;

    // Single-beat, single-ID traffic: these response fields carry no information.
    logic unused_rsp_fields;
    assign unused_rsp_fields = ^{o_axi_rid, o_axi_rlast, o_axi_bid, o_axi_rresp[0], o_axi_bresp[0]};

endmodule

// File: tb/tb_icb2axi_mport.sv
// Directed self-checking bench for icb2axi_mport (default 64-bit configuration).
module tb_icb2axi_mport;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wmask = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [63:0] rsp_rdata;

    logic        arvalid, arready = 1'b0, arlock;
    logic [3:0]  arid, arcache;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        awvalid, awready = 1'b0, awlock;
    logic [3:0]  awid, awcache;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic        wvalid, wready = 1'b0, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        rvalid = 1'b0, rready, rlast = 1'b1;
    logic [3:0]  rid = '0, bid = '0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        bvalid = 1'b0, bready;

    int n_chk  = 0;
    int n_pass = 0;

    icb2axi_mport dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_read(cmd_read),
        .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_err(rsp_err),
        .i_icb_rsp_rdata(rsp_rdata),
        .o_axi_arvalid(arvalid), .o_axi_arready(arready), .o_axi_arid(arid), .o_axi_araddr(araddr),
        .o_axi_arlen(arlen), .o_axi_arsize(arsize), .o_axi_arburst(arburst), .o_axi_arlock(arlock),
        .o_axi_arcache(arcache), .o_axi_arprot(arprot),
        .o_axi_awvalid(awvalid), .o_axi_awready(awready), .o_axi_awid(awid), .o_axi_awaddr(awaddr),
        .o_axi_awlen(awlen), .o_axi_awsize(awsize), .o_axi_awburst(awburst), .o_axi_awlock(awlock),
        .o_axi_awcache(awcache), .o_axi_awprot(awprot),
        .o_axi_wvalid(wvalid), .o_axi_wready(wready), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
        .o_axi_wlast(wlast),
        .o_axi_rvalid(rvalid), .o_axi_rready(rready), .o_axi_rid(rid), .o_axi_rdata(rdata),
        .o_axi_rresp(rresp), .o_axi_rlast(rlast),
        .o_axi_bvalid(bvalid), .o_axi_bready(bready), .o_axi_bid(bid), .o_axi_bresp(bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until accepted, bounded.
    task automatic issue(input logic rd, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        bit done = 1'b0;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // reset state
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // T1: single read
        issue(1'b1, 32'h1000, 64'd0, 8'h00);
        chk("t1_arvalid_lat", 64'(arvalid), 64'd1);
        chk("t1_araddr", 64'(araddr), 64'h1000);
        chk("t1_arsize", 64'(arsize), 64'd3);
        chk("t1_arlen", 64'(arlen), 64'd0);
        chk("t1_arburst", 64'(arburst), 64'd1);
        chk("t1_arcache", 64'(arcache), 64'd3);
        chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("t1_arvalid_clr", 64'(arvalid), 64'd0);
        chk("t1_cmd_ready_free", 64'(cmd_ready), 64'd1);
        rvalid = 1'b1; rdata = 64'hDEADBEEF_00C0FFEE; rresp = 2'b00; rsp_ready = 1'b1;
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_rdata", rsp_rdata, 64'hDEADBEEF_00C0FFEE);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        chk("t1_rready", 64'(rready), 64'd1);
        tick();
        rvalid = 1'b0;
        #1;
        chk("t1_rsp_empty", 64'(rsp_valid), 64'd0);

        // T2: write, AW stalled 5 cycles, W immediate
        rsp_ready = 1'b0;
        wready = 1'b1;
        issue(1'b0, 32'h2000, 64'h1122334455667788, 8'h0F);
        chk("t2_awvalid", 64'(awvalid), 64'd1);
        chk("t2_wvalid", 64'(wvalid), 64'd1);
        chk("t2_awaddr", 64'(awaddr), 64'h2000);
        chk("t2_wstrb", 64'(wstrb), 64'h0F);
        chk("t2_wdata", wdata, 64'h1122334455667788);
        chk("t2_wlast", 64'(wlast), 64'd1);
        tick();
        wready = 1'b0;
        chk("t2_w_first", 64'(wvalid), 64'd0);
        repeat (4) tick();
        chk("t2_aw_held", 64'(awvalid), 64'd1);
        chk("t2_cmd_ready_aw", 64'(cmd_ready), 64'd0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t2_aw_done", 64'(awvalid), 64'd0);
        chk("t2_cmd_ready_free", 64'(cmd_ready), 64'd1);
        bvalid = 1'b1; bresp = 2'b00; rvalid = 1'b1; rdata = 64'hFFFF; rsp_ready = 1'b1;
        #1;
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_err", 64'(rsp_err), 64'd0);
        chk("t2_rsp_rdata", rsp_rdata, 64'd0);
        chk("t2_bready", 64'(bready), 64'd1);
        chk("t2_rready_held", 64'(rready), 64'd0);
        tick();
        bvalid = 1'b0; rvalid = 1'b0;

        // T3: RD, WR, RD with B returned before both Rs
        arready = 1'b1; awready = 1'b1; wready = 1'b1; rsp_ready = 1'b0;
        issue(1'b1, 32'h3000, 64'd0, 8'h00);
        issue(1'b0, 32'h3008, 64'hA5A5, 8'hFF);
        issue(1'b1, 32'h3010, 64'd0, 8'h00);
        tick();
        bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
        #1;
        chk("t3_bready_held", 64'(bready), 64'd0);
        chk("t3_no_rsp_yet", 64'(rsp_valid), 64'd0);
        tick();
        rvalid = 1'b1; rdata = 64'h0000_0000_0000_0A01;
        #1;
        chk("t3_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("t3_rsp1_rdata", rsp_rdata, 64'h0A01);
        chk("t3_rsp1_bready", 64'(bready), 64'd0);
        tick();
        rdata = 64'h0000_0000_0000_0A02;
        #1;
        chk("t3_rsp2_valid", 64'(rsp_valid), 64'd1);
        chk("t3_rsp2_rdata_zero", rsp_rdata, 64'd0);
        chk("t3_rsp2_bready", 64'(bready), 64'd1);
        chk("t3_rsp2_rready", 64'(rready), 64'd0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("t3_rsp3_rdata", rsp_rdata, 64'h0A02);
        chk("t3_rsp3_rready", 64'(rready), 64'd1);
        tick();
        rvalid = 1'b0; rsp_ready = 1'b0;

        // T4: fill the order FIFO with 8 reads
        for (int i = 0; i < 8; i++) issue(1'b1, 32'h4000 + 32'(i * 8), 64'd0, 8'h00);
        tick();
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h4040;
        #1;
        chk("t4_full_ready", 64'(cmd_ready), 64'd0);
        tick();
        chk("t4_full_ready2", 64'(cmd_ready), 64'd0);
        rvalid = 1'b1; rdata = 64'h100; rsp_ready = 1'b1;
        #1;
        chk("t4_pop_valid", 64'(rsp_valid), 64'd1);
        chk("t4_ready_during_pop", 64'(cmd_ready), 64'd0);
        tick();
        rvalid = 1'b0;
        #1;
        chk("t4_ready_after_pop", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            rvalid = 1'b1; rdata = 64'h100 + 64'(i);
            #1;
            chk($sformatf("t4_drain%0d", i), {63'd0, rsp_valid} + rsp_rdata, 64'h101 + 64'(i));
            tick();
        end
        #1;
        chk("t4_empty_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t4_empty_rready", 64'(rready), 64'd0);
        rvalid = 1'b0;

        // T5: error responses
        issue(1'b1, 32'h5000, 64'd0, 8'h00);
        tick();
        rvalid = 1'b1; rresp = 2'b10; rdata = 64'h55;
        #1;
        chk("t5_slverr", 64'(rsp_err), 64'd1);
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        issue(1'b0, 32'h5008, 64'h66, 8'hFF);
        tick();
        bvalid = 1'b1; bresp = 2'b11;
        #1;
        chk("t5_decerr", 64'(rsp_err), 64'd1);
        chk("t5_decerr_valid", 64'(rsp_valid), 64'd1);
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        issue(1'b1, 32'h5010, 64'd0, 8'h00);
        tick();
        rvalid = 1'b1; rresp = 2'b01;
        #1;
        chk("t5_exokay", 64'(rsp_err), 64'd0);
        tick();
        rvalid = 1'b0; rresp = 2'b00; rsp_ready = 1'b0;

        // T6: misaligned read
`ifdef ICB2AXI_MISALIGN_CHK_EN
        issue(1'b1, 32'h1003, 64'd0, 8'h00);
        chk("t6_no_arvalid", 64'(arvalid), 64'd0);
        chk("t6_rsp_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t6_rsp_err", 64'(rsp_err), 64'd1);
        chk("t6_rsp_rdata", rsp_rdata, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t6_popped", 64'(rsp_valid), 64'd0);
`else
        arready = 1'b0;
        issue(1'b1, 32'h1003, 64'd0, 8'h00);
        chk("t6_arvalid", 64'(arvalid), 64'd1);
        chk("t6_araddr", 64'(araddr), 64'h1003);
        arready = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 64'h77; rsp_ready = 1'b1;
        #1;
        chk("t6_rsp_rdata", rsp_rdata, 64'h77);
        tick();
        rvalid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("t6_popped", 64'(rsp_valid), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
